// File: rtl/spi_target_pkg.sv
// Shared types, register decode constants and STATUS packing for the SPI target.
`include "spi_target_defs.vh"

package spi_target_pkg;

  typedef enum logic {StIdle, StActive} state_e;

  localparam logic [1:0] AddrData   = `SPI_ADDR_DATA;
  localparam logic [1:0] AddrStatus = `SPI_ADDR_STATUS;
  localparam logic [1:0] AddrCtrl   = `SPI_ADDR_CTRL;

  function automatic logic [31:0] status_word(input logic rx_valid, input logic tx_full,
                                              input logic overrun, input logic underrun,
                                              input logic cs_active);
    logic [31:0] w;
    w = '0;
    w[`SPI_ST_RX_VALID]  = rx_valid;
    w[`SPI_ST_TX_EMPTY]  = ~tx_full;
    w[`SPI_ST_OVERRUN]   = overrun;
    w[`SPI_ST_UNDERRUN]  = underrun;
    w[`SPI_ST_CS_ACTIVE] = cs_active;
    return w;
  endfunction

endpackage

// File: rtl/spi_target_defs.vh
// Register offsets and STATUS/CTRL bit positions shared by the SPI target and its package.
`ifndef SPI_TARGET_DEFS_VH
`define SPI_TARGET_DEFS_VH

`define SPI_ADDR_DATA    2'd0
`define SPI_ADDR_STATUS  2'd1
`define SPI_ADDR_CTRL    2'd2

`define SPI_ST_RX_VALID  0
`define SPI_ST_TX_EMPTY  1
`define SPI_ST_OVERRUN   2
`define SPI_ST_UNDERRUN  3
`define SPI_ST_CS_ACTIVE 4

`define SPI_CTRL_IE_RX   0
`define SPI_CTRL_IE_TX   1
`define SPI_CTRL_IE_ERR  2

`endif

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a history flop; flags rising/falling edges of the synced level.
module sync_edge #(
  parameter bit IDLE = 1'b1
) (
  input  logic clk,
  input  logic resetq,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
      hist_q <= IDLE;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_target.sv
// SPI target with CPU register interface: one-byte rx/tx holding registers, status and interrupts.
`include "spi_target_defs.vh"

module spi_target
  import spi_target_pkg::*;
#(
  parameter bit POLARITY = 1'b1
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        select,
  input  logic [3:0]  we,
  input  logic        rd,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        intr,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  logic unused_sck_level, sck_rise, sck_fall, cs_level, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_sync_q;
  logic unused_bits;

  sync_edge #(.IDLE(POLARITY)) u_sck (
    .clk(clk), .resetq(resetq), .din(spi_sck),
    .level(unused_sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.IDLE(1'b1)) u_cs (
    .clk(clk), .resetq(resetq), .din(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_bits = ^{we[3:1], wdata[31:8]};

  logic leading, trailing;
  assign leading  = POLARITY ? sck_fall : sck_rise;
  assign trailing = POLARITY ? sck_rise : sck_fall;

  logic data_rd, data_wr, stat_wr, ctrl_wr;
  assign data_rd = select & rd & (addr == AddrData);
  assign data_wr = select & we[0] & (addr == AddrData);
  assign stat_wr = select & we[0] & (addr == AddrStatus);
  assign ctrl_wr = select & we[0] & (addr == AddrCtrl);

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d, ie_q, ie_d;
  logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0]  rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
  logic        rx_valid_q, rx_valid_d, tx_full_q, tx_full_d;
  logic        overrun_q, overrun_d, underrun_q, underrun_d;
  logic        intr_q, tx_load, byte_done;
  logic [1:0]  settle_q;
  logic        armed_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_hold_d  = rx_hold_q;
    rx_valid_d = rx_valid_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    ie_d       = ie_q;
    tx_load    = 1'b0;
    byte_done  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fall && armed_q) begin
          state_d   = StActive;
          bit_cnt_d = 3'd0;
          tx_load   = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d   = StIdle;
          bit_cnt_d = 3'd0;
        end else if (leading) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (trailing) begin
          // A trailing edge seen with a wrapped counter closes a full byte.
          if (bit_cnt_q == 3'd0) tx_load = 1'b1;
          else                   tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
      end
      default: state_d = StIdle;
    endcase

    // Clears first so that same-cycle hardware sets take priority.
    if (data_rd) rx_valid_d = 1'b0;
    if (stat_wr && wdata[`SPI_ST_OVERRUN])  overrun_d  = 1'b0;
    if (stat_wr && wdata[`SPI_ST_UNDERRUN]) underrun_d = 1'b0;

    if (byte_done) begin
      rx_hold_d  = {rx_shift_q[6:0], mosi_sync_q};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !data_rd) overrun_d = 1'b1;
    end

    if (tx_load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_hold_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = 8'hFF;
        underrun_d = 1'b1;
      end
    end

    if (data_wr) begin
      tx_hold_d = wdata[7:0];
      tx_full_d = 1'b1;
    end

    if (ctrl_wr) ie_d = wdata[2:0];
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'hFF;
      rx_hold_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_hold_q   <= 8'h00;
      tx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      ie_q        <= 3'd0;
      intr_q      <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_hold_q   <= rx_hold_d;
      rx_valid_q  <= rx_valid_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      ie_q        <= ie_d;
      intr_q      <= (ie_q[`SPI_CTRL_IE_RX] & rx_valid_q) |
                     (ie_q[`SPI_CTRL_IE_TX] & ~tx_full_q) |
                     (ie_q[`SPI_CTRL_IE_ERR] & (overrun_q | underrun_q));
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      // CS must be seen high on a settled synchroniser before a falling edge counts after reset.
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && cs_level) armed_q <= 1'b1;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      AddrData:   rdata = {24'h0, rx_hold_q};
      AddrStatus: rdata = status_word(rx_valid_q, tx_full_q, overrun_q, underrun_q,
                                      state_q == StActive);
      AddrCtrl:   rdata = {29'h0, ie_q};
      default:    rdata = 32'h0;
    endcase
  end

  assign intr        = intr_q;
  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = (state_q == StActive);

endmodule
